// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
// Contents:
//   - rx_state_e       : receiver state encoding
//   - LCR_*            : line-control register field positions
//   - PAR_*            : parity mode codes, LCR[5:3] with LCR[3] = enable
//   - RX_ENTRY_W / RX_*: receive FIFO entry layout {break, fe, pe, data[7:0]}
//   - parity_expected(): expected parity bit for a mode and a data byte
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  // LCR field positions
  localparam int LCR_WLS_LSB   = 0;
  localparam int LCR_WLS_MSB   = 1;
  localparam int LCR_PEN       = 3;
  localparam int LCR_PMODE_LSB = 3;
  localparam int LCR_PMODE_MSB = 5;

  // Parity modes as seen in LCR[5:3]
  localparam logic [2:0] PAR_ODD    = 3'b001;
  localparam logic [2:0] PAR_EVEN   = 3'b011;
  localparam logic [2:0] PAR_STICK1 = 3'b101;
  localparam logic [2:0] PAR_STICK0 = 3'b111;

  // Receive FIFO entry layout
  localparam int RX_ENTRY_W = 11;
  localparam int RX_BREAK   = 10;
  localparam int RX_FE      = 9;
  localparam int RX_PE      = 8;

  // Tick counter points within a 16-tick bit period
  localparam logic [3:0] TICK_MID = 4'd7;
  localparam logic [3:0] TICK_END = 4'd15;

  function automatic logic parity_expected(input logic [2:0] mode,
                                           input logic [7:0] data);
    case (mode)
      PAR_ODD:    return ~^data;
      PAR_EVEN:   return ^data;
      PAR_STICK1: return 1'b1;
      default:    return 1'b0;  // PAR_STICK0
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Synchronous show-ahead FIFO for received characters. DEPTH must be a power
// of two so the pointers wrap naturally.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_wdata (dropped when full unless popping this cycle)
//   i_wdata    : entry to write
//   i_pop      : advance the head (ignored when empty)
//   o_rdata    : current head, zero while empty
//   o_empty    : no entries
//   o_full     : DEPTH entries
//   o_count    : occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign o_count   = r_count;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a
  // simultaneous push.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count need one,
  // and a reset-free array maps onto plain RAM/register files.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// UART receive path: synchronizes RXD, recovers 5..8 bit characters using the
// 16x baud enable tick, checks parity/framing/break and queues each character
// with its status into a show-ahead receive FIFO.
// Ports:
//   PCLK, PRESETn  : clock, asynchronous active-low reset
//   RXD            : serial input, idle high
//   enable         : 16x baud tick, one PCLK wide
//   LCR            : [1:0] word length-5, [3] parity enable, [5:3] parity mode
//   rx_fifo_pop    : pop the FIFO head
//   lsr_rd         : clears the sticky overrun flag
//   rx_fifo_out    : FIFO head {break, framing_err, parity_err, data[7:0]}
//   rx_fifo_empty  : FIFO empty
//   rx_fifo_full   : FIFO full
//   rx_fifo_count  : FIFO occupancy
//   overrun        : sticky, a character arrived while the FIFO was full
//   busy           : receiver is between start detection and IDLE
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2     // at least 2
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic                          RXD,
  input  logic                          enable,
  input  logic [7:0]                    LCR,
  input  logic                          rx_fifo_pop,
  input  logic                          lsr_rd,
  output logic [RX_ENTRY_W-1:0]         rx_fifo_out,
  output logic                          rx_fifo_empty,
  output logic                          rx_fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   rx_fifo_count,
  output logic                          overrun,
  output logic                          busy
);

  // Synchronizer
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rxd_s;

  // Receiver state and datapath
  rx_state_e              r_state,       w_state_nxt;
  logic [3:0]             r_tick_cnt,    w_tick_nxt;
  logic [2:0]             r_bit_idx,     w_bit_idx_nxt;
  logic [7:0]             r_shift,       w_shift_nxt;
  logic [1:0]             r_wls,         w_wls_nxt;
  logic [2:0]             r_pmode,       w_pmode_nxt;   // [0] = parity enable
  logic                   r_par_bit,     w_par_bit_nxt;
  logic                   r_par_err,     w_par_err_nxt;
  logic                   r_push,        w_push_nxt;
  logic [RX_ENTRY_W-1:0]  r_push_data,   w_push_data_nxt;
  logic                   r_overrun;
  logic                   w_ovr_set;
  logic                   w_brk;
  logic                   w_unused_lcr;

  // LCR[2] (stop bits) and LCR[7:6] do not affect the receiver.
  assign w_unused_lcr = ^{LCR[7:6], LCR[2]};

  assign w_rxd_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_sync <= '1;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], RXD};
  end

  // Break: all-zero character, zero parity bit (when present) and zero stop.
  assign w_brk = (r_shift == 8'h00) && !(r_pmode[0] && r_par_bit) && !w_rxd_s;

  always_comb begin
    // NOTE: every next value defaults to its current register before the case
    // so no path leaves a variable unassigned and no latch is inferred.
    w_state_nxt     = r_state;
    w_tick_nxt      = r_tick_cnt;
    w_bit_idx_nxt   = r_bit_idx;
    w_shift_nxt     = r_shift;
    w_wls_nxt       = r_wls;
    w_pmode_nxt     = r_pmode;
    w_par_bit_nxt   = r_par_bit;
    w_par_err_nxt   = r_par_err;
    w_push_nxt      = 1'b0;
    w_push_data_nxt = r_push_data;

    if (enable) begin
      case (r_state)
        RX_IDLE: begin
          if (!w_rxd_s) begin
            // Frame format is frozen here; later LCR writes wait for the next start.
            w_wls_nxt     = LCR[LCR_WLS_MSB:LCR_WLS_LSB];
            w_pmode_nxt   = LCR[LCR_PMODE_MSB:LCR_PMODE_LSB];
            w_tick_nxt    = '0;
            w_bit_idx_nxt = '0;
            w_shift_nxt   = '0;
            w_par_bit_nxt = 1'b0;
            w_par_err_nxt = 1'b0;
            w_state_nxt   = RX_START;
          end
        end

        RX_START: begin
          if (r_tick_cnt == TICK_MID) begin
            if (w_rxd_s) begin
              w_state_nxt = RX_IDLE;       // glitch, not a start bit
            end else begin
              w_tick_nxt  = '0;
              w_state_nxt = RX_DATA;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + 4'd1;
          end
        end

        RX_DATA: begin
          // Counter wraps 15 -> 0, so each sample starts the next 16-tick period.
          w_tick_nxt = r_tick_cnt + 4'd1;
          if (r_tick_cnt == TICK_END) begin
            w_shift_nxt[r_bit_idx] = w_rxd_s;
            // Last data index is 4 + word-length code.
            if (r_bit_idx == {1'b1, r_wls}) begin
              w_bit_idx_nxt = '0;
              w_state_nxt   = r_pmode[0] ? RX_PARITY : RX_STOP;
            end else begin
              w_bit_idx_nxt = r_bit_idx + 3'd1;
            end
          end
        end

        RX_PARITY: begin
          w_tick_nxt = r_tick_cnt + 4'd1;
          if (r_tick_cnt == TICK_END) begin
            w_par_bit_nxt = w_rxd_s;
            w_par_err_nxt = (w_rxd_s != parity_expected(r_pmode, r_shift));
            w_state_nxt   = RX_STOP;
          end
        end

        RX_STOP: begin
          w_tick_nxt = r_tick_cnt + 4'd1;
          if (r_tick_cnt == TICK_END) begin
            w_push_nxt                = 1'b1;
            w_push_data_nxt           = '0;
            w_push_data_nxt[7:0]      = r_shift;
            w_push_data_nxt[RX_PE]    = r_par_err;
            w_push_data_nxt[RX_FE]    = !w_rxd_s;
            w_push_data_nxt[RX_BREAK] = w_brk;
            // A low stop bit parks the receiver until the line goes idle so a
            // held break yields a single entry.
            w_state_nxt = w_rxd_s ? RX_IDLE : RX_WAIT_HIGH;
          end
        end

        RX_WAIT_HIGH: begin
          if (w_rxd_s) w_state_nxt = RX_IDLE;
        end

        default: w_state_nxt = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= RX_IDLE;
      r_tick_cnt  <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_wls       <= '0;
      r_pmode     <= '0;
      r_par_bit   <= 1'b0;
      r_par_err   <= 1'b0;
      r_push      <= 1'b0;
      r_push_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_tick_cnt  <= w_tick_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_wls       <= w_wls_nxt;
      r_pmode     <= w_pmode_nxt;
      r_par_bit   <= w_par_bit_nxt;
      r_par_err   <= w_par_err_nxt;
      r_push      <= w_push_nxt;
      r_push_data <= w_push_data_nxt;
    end
  end

  // A push into a full FIFO is dropped unless a pop frees a slot this cycle.
  assign w_ovr_set = r_push && rx_fifo_full && !rx_fifo_pop;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)       r_overrun <= 1'b0;
    else if (w_ovr_set) r_overrun <= 1'b1;   // set wins over a same-cycle clear
    else if (lsr_rd)    r_overrun <= 1'b0;
  end

  assign overrun = r_overrun;
  assign busy    = (r_state != RX_IDLE);

  uart_rx_fifo #(
    .WIDTH (RX_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .i_push  (r_push),
    .i_wdata (r_push_data),
    .i_pop   (rx_fifo_pop),
    .o_rdata (rx_fifo_out),
    .o_empty (rx_fifo_empty),
    .o_full  (rx_fifo_full),
    .o_count (rx_fifo_count)
  );

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx. One baud tick is three PCLK cycles with enable
// high across the middle rising edge; inputs change on falling edges and
// outputs are sampled on falling edges.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  logic        PCLK;
  logic        PRESETn;
  logic        RXD;
  logic        enable;
  logic [7:0]  LCR;
  logic        rx_fifo_pop;
  logic        lsr_rd;
  logic [10:0] rx_fifo_out;
  logic        rx_fifo_empty;
  logic        rx_fifo_full;
  logic [4:0]  rx_fifo_count;
  logic        overrun;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  uart_rx #(
    .FIFO_DEPTH  (16),
    .SYNC_STAGES (2)
  ) dut (
    .PCLK          (PCLK),
    .PRESETn       (PRESETn),
    .RXD           (RXD),
    .enable        (enable),
    .LCR           (LCR),
    .rx_fifo_pop   (rx_fifo_pop),
    .lsr_rd        (lsr_rd),
    .rx_fifo_out   (rx_fifo_out),
    .rx_fifo_empty (rx_fifo_empty),
    .rx_fifo_full  (rx_fifo_full),
    .rx_fifo_count (rx_fifo_count),
    .overrun       (overrun),
    .busy          (busy)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge PCLK); enable = 1'b1;
      @(negedge PCLK); enable = 1'b0;
      @(negedge PCLK);
    end
  endtask

  // Serial frame, 16 ticks per bit. With pop_at_push the pop is raised in the
  // cycle the stop-bit push reaches the FIFO (start seen on tick 2, so every
  // bit is sampled on its tick 10 and the push lands one cycle later).
  task automatic send_frame(input logic [7:0] data, input int nbits,
                            input bit par_en, input bit par_val,
                            input bit stop_val, input bit pop_at_push);
    RXD = 1'b0;
    ticks(16);
    for (int i = 0; i < nbits; i++) begin
      RXD = data[i];
      ticks(16);
    end
    if (par_en) begin
      RXD = par_val;
      ticks(16);
    end
    RXD = stop_val;
    if (pop_at_push) begin
      ticks(9);
      @(negedge PCLK); enable = 1'b1;
      @(negedge PCLK); enable = 1'b0; rx_fifo_pop = 1'b1;
      @(negedge PCLK); rx_fifo_pop = 1'b0;
      ticks(6);
    end else begin
      ticks(16);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [10:0] exp);
    check(tag, 32'(rx_fifo_out), 32'(exp));
    rx_fifo_pop = 1'b1;
    @(negedge PCLK);
    rx_fifo_pop = 1'b0;
    @(negedge PCLK);
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_busy"},  32'(busy),          32'd0);
    check({tag, "_ovr"},   32'(overrun),       32'd0);
    check({tag, "_empty"}, 32'(rx_fifo_empty), 32'd1);
    check({tag, "_full"},  32'(rx_fifo_full),  32'd0);
    check({tag, "_count"}, 32'(rx_fifo_count), 32'd0);
    check({tag, "_out"},   32'(rx_fifo_out),   32'd0);
  endtask

  initial begin
    PRESETn     = 1'b0;
    RXD         = 1'b1;
    enable      = 1'b0;
    LCR         = 8'h03;
    rx_fifo_pop = 1'b0;
    lsr_rd      = 1'b0;
    repeat (3) @(negedge PCLK);
    chk_reset_vals("rst");
    PRESETn = 1'b1;
    ticks(4);

    // 8N1, 0xA5
    LCR = 8'h03;
    send_frame(8'hA5, 8, 0, 0, 1, 0);
    check("8n1_count", 32'(rx_fifo_count), 32'd1);
    check("8n1_busy",  32'(busy),          32'd0);
    pop_chk("8n1_head", 11'h0A5);
    check("8n1_empty", 32'(rx_fifo_empty), 32'd1);

    // 8E1, 0x37 (five ones, even parity bit should be 1), send 0
    LCR = 8'h1B;
    send_frame(8'h37, 8, 1, 0, 1, 0);
    pop_chk("8e1_perr", 11'h137);
    // 8O1, 0x37, odd parity bit 0 is correct
    LCR = 8'h0B;
    send_frame(8'h37, 8, 1, 0, 1, 0);
    pop_chk("8o1_ok", 11'h037);

    // 5N1, 0x15 with low stop bit, then a 3-character break
    LCR = 8'h00;
    send_frame(8'h15, 5, 0, 0, 0, 0);
    check("fe_count", 32'(rx_fifo_count), 32'd1);
    check("fe_head",  32'(rx_fifo_out),   32'h215);
    check("fe_wait_busy", 32'(busy),      32'd1);
    RXD = 1'b1;
    ticks(4);
    check("fe_idle_busy", 32'(busy),      32'd0);
    RXD = 1'b0;
    ticks(3 * 7 * 16);
    check("brk_count", 32'(rx_fifo_count), 32'd2);
    check("brk_busy",  32'(busy),          32'd1);
    RXD = 1'b1;
    ticks(8);
    check("brk_idle_busy",  32'(busy),          32'd0);
    check("brk_idle_count", 32'(rx_fifo_count), 32'd2);
    pop_chk("brk_first", 11'h215);
    pop_chk("brk_entry", 11'h600);

    // 6-tick glitch on idle line
    LCR = 8'h03;
    RXD = 1'b0;
    ticks(6);
    check("glitch_busy_hi", 32'(busy), 32'd1);
    RXD = 1'b1;
    ticks(12);
    check("glitch_busy_lo", 32'(busy),          32'd0);
    check("glitch_count",   32'(rx_fifo_count), 32'd0);

    // Fill, overrun, clear, push with simultaneous pop
    for (int i = 0; i < 16; i++) send_frame(8'(8'h40 + i), 8, 0, 0, 1, 0);
    check("fill_count", 32'(rx_fifo_count), 32'd16);
    check("fill_full",  32'(rx_fifo_full),  32'd1);
    check("fill_ovr",   32'(overrun),       32'd0);
    send_frame(8'h50, 8, 0, 0, 1, 0);
    check("ovr_set",   32'(overrun),       32'd1);
    check("ovr_count", 32'(rx_fifo_count), 32'd16);
    check("ovr_head",  32'(rx_fifo_out),   32'h040);
    lsr_rd = 1'b1;
    @(negedge PCLK);
    lsr_rd = 1'b0;
    check("ovr_clear", 32'(overrun), 32'd0);
    send_frame(8'h51, 8, 0, 0, 1, 1);
    check("pp_ovr",   32'(overrun),       32'd0);
    check("pp_count", 32'(rx_fifo_count), 32'd16);
    check("pp_head",  32'(rx_fifo_out),   32'h041);

    // Reset in the middle of frame 3's data
    send_frame(8'h11, 8, 0, 0, 1, 0);
    check("pre_rst_ovr", 32'(overrun), 32'd1);
    send_frame(8'h22, 8, 0, 0, 1, 0);
    RXD = 1'b0;
    ticks(16);
    for (int i = 0; i < 4; i++) begin
      RXD = 1'(8'h33 >> i);
      ticks(16);
    end
    RXD = 1'b1;            // bit 4 of 0x33
    ticks(8);
    check("mid_busy", 32'(busy), 32'd1);
    PRESETn = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    RXD = 1'b1;
    ticks(20);
    check("post_rst_count", 32'(rx_fifo_count), 32'd0);
    send_frame(8'h3C, 8, 0, 0, 1, 0);
    check("post_rst_count1", 32'(rx_fifo_count), 32'd1);
    pop_chk("post_rst_head", 11'h03C);
    check("post_rst_empty", 32'(rx_fifo_empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
